fb_ram_arbiter: RTL and testbench

Shares the single-port 320x240 byte framebuffer RAM (one access per cycle, 1-cycle read latency) between three requesters: the display read stream, the waterfall pixel writer, and a built-in clear engine.
It sits directly in front of the framebuffer RAM block and drives its addr/wdata/w_enable.
Display reads have priority. A starvation counter guarantees that background writes always make forward progress.

---
 rtl/fb_ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_fb_ram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_ram_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port RAM between the display
// read stream, the waterfall pixel writer and a full-frame clear engine.
// Reads win by default; a starvation counter hands the background requester
// one cycle after MAX_WAIT consecutive blocked cycles.
module fb_ram_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 76800,
    parameter int MAX_WAIT    = 8,
    parameter int CLEAR_VALUE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              oob_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] CLEAR_BYTE = DATA_W'(CLEAR_VALUE);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] clear_cnt;
    logic              rd_oob_q;

    logic bg_req;
    logic starve;
    logic bg_grant;
    logic wr_grant;
    logic clr_grant;
    logic clr_last;
    logic rd_oob;
    logic wr_oob;

    assign rd_oob = ({1'b0, rd_addr} >= DEPTH_X);
    assign wr_oob = ({1'b0, wr_addr} >= DEPTH_X);

    // Grant decision: read unless the background requester has starved.
    always_comb begin
        bg_req    = (state == CLEAR) ? 1'b1 : wr_valid;
        starve    = bg_req && (wait_cnt == WAIT_MAX);
        rd_ready  = rd_req && !starve;
        bg_grant  = bg_req && (!rd_req || starve);
        wr_grant  = bg_grant && (state == IDLE);
        clr_grant = bg_grant && (state == CLEAR);
        clr_last  = clr_grant && (clear_cnt == LAST_ADDR);
        wr_ready  = wr_grant;
    end

    // RAM port mux driven straight from the grant; zeros when idle.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (rd_ready) begin
            ram_addr = rd_addr;
        end else if (wr_grant) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            ram_we    = !wr_oob;
        end else if (clr_grant) begin
            ram_addr  = clear_cnt;
            ram_wdata = CLEAR_BYTE;
            ram_we    = 1'b1;
        end
    end

    // Next-state logic: clear_start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, starvation counter, clear address and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            clear_cnt  <= '0;
            clear_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clear_done <= clr_last;
            if (!bg_req || bg_grant) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == IDLE && clear_start) begin
                clear_cnt <= '0;
            end else if (clr_grant) begin
                clear_cnt <= clear_cnt + 1'b1;
            end
            if (wr_grant && wr_oob) begin
                oob_err <= 1'b1;
            end
        end
    end

    // Read return pipeline: valid and the out-of-range mask travel together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_valid <= 1'b0;
            rd_oob_q      <= 1'b0;
        end else begin
            rd_data_valid <= rd_ready;
            rd_oob_q      <= rd_ready && rd_oob;
        end
    end

    assign clear_busy = (state == CLEAR);
    assign rd_data    = (rd_data_valid && !rd_oob_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Self-checking bench for fb_ram_arbiter: vector table for single-cycle
// grant decisions, read scoreboard, clear-address tracker and hand-written
// multi-cycle sequences for contention, clear and reset corner cases.
module tb_fb_ram_arbiter;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;
    localparam int DEPTH_T  = 600;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              oob_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata = '0;

    fb_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH_T),
        .MAX_WAIT   (MAX_WAIT),
        .CLEAR_VALUE(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ready     (rd_ready),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .oob_err      (oob_err),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM stand-in: synchronous read returning the low address byte.
    always @(posedge clk) ram_rdata <= ram_addr[7:0];

    int n_chk  = 0;
    int n_pass = 0;
    logic [DATA_W-1:0] rd_q[$];
    int   clr_exp  = 0;
    int   done_cnt = 0;
    logic prev_rd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic              rd_req;
        logic [ADDR_W-1:0] rd_addr;
        logic              wr_valid;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              e_rd_ready;
        logic              e_wr_ready;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
    } vec_t;

    function automatic vec_t mkv(input int rq, input int ra, input int wv, input int wa,
                                 input int wd, input int er, input int ew, input int ewe,
                                 input int ea, input int ewd);
        vec_t v;
        v.rd_req     = 1'(rq);
        v.rd_addr    = ADDR_W'(ra);
        v.wr_valid   = 1'(wv);
        v.wr_addr    = ADDR_W'(wa);
        v.wr_data    = DATA_W'(wd);
        v.e_rd_ready = 1'(er);
        v.e_wr_ready = 1'(ew);
        v.e_we       = 1'(ewe);
        v.e_addr     = ADDR_W'(ea);
        v.e_wdata    = DATA_W'(ewd);
        return v;
    endfunction

    // Monitor: read latency/data scoreboard, grant exclusivity, clear writes.
    always @(negedge clk) begin
        if (reset) begin
            prev_rd_ready = 1'b0;
        end else begin
            chk("rd_valid_latency", 32'(rd_data_valid), 32'(prev_rd_ready));
            if (rd_data_valid) begin
                chk("rd_queue_nonempty", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
            if (rd_ready)
                rd_q.push_back((int'(rd_addr) >= DEPTH_T) ? 8'h00 : rd_addr[7:0]);
            prev_rd_ready = rd_ready;
            chk("single_grant", 32'(rd_ready && wr_ready), 32'd0);
            if (clear_busy) chk("wr_ready_in_clear", 32'(wr_ready), 32'd0);
            if (ram_we && !rd_ready && !wr_ready) begin
                chk("clear_addr", 32'(ram_addr), 32'(clr_exp));
                chk("clear_wdata", 32'(ram_wdata), 32'd0);
                clr_exp++;
            end
            if (clear_done) done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_start = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs until clear_done, counting busy cycles; optional read stream.
    task automatic run_clear(input bit with_reads, input int limit,
                             output int busy, output bit got);
        bit ready;
        busy = 0;
        got  = 1'b0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            ready = rd_ready;
            if (clear_busy) busy++;
            if (clear_done) got = 1'b1;
            next_cycle();
            clear_start = with_reads ? 1'b0 : (c == 50);
            if (with_reads && ready) rd_addr = rd_addr + 1'b1;
        end
    endtask

    vec_t vt[11];
    int   busy;
    bit   got;

    initial begin
        idle_inputs();
        reset = 1'b1;
        vt[0]  = mkv(0, 0,       0, 0,       0,    0, 0, 0, 0,       0);
        vt[1]  = mkv(1, 5,       0, 0,       0,    1, 0, 0, 5,       0);
        vt[2]  = mkv(0, 0,       1, 7,       'hAB, 0, 1, 1, 7,       'hAB);
        vt[3]  = mkv(1, 9,       1, 10,      'h11, 1, 0, 0, 9,       0);
        vt[4]  = mkv(0, 0,       0, 0,       0,    0, 0, 0, 0,       0);
        vt[5]  = mkv(0, 0,       1, DEPTH_T, 'h55, 0, 1, 0, DEPTH_T, 'h55);
        vt[6]  = mkv(1, DEPTH_T, 0, 0,       0,    1, 0, 0, DEPTH_T, 0);
        vt[7]  = mkv(0, 0,       1, DEPTH_T - 1, 'hC3, 0, 1, 1, DEPTH_T - 1, 'hC3);
        vt[8]  = mkv(1, DEPTH_T - 1, 0, 0,   0,    1, 0, 0, DEPTH_T - 1, 0);
        vt[9]  = mkv(1, 'h1FFFF, 1, 4,       'h44, 1, 0, 0, 'h1FFFF, 0);
        vt[10] = mkv(0, 0,       1, 4,       'h44, 0, 1, 1, 4,       'h44);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_oob_err", 32'(oob_err), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Single-cycle grant table
        for (int i = 0; i < 11; i++) begin
            rd_req = vt[i].rd_req; rd_addr = vt[i].rd_addr;
            wr_valid = vt[i].wr_valid; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
            @(negedge clk);
            chk($sformatf("vec%0d_rd_ready", i), 32'(rd_ready), 32'(vt[i].e_rd_ready));
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vt[i].e_wr_ready));
            chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vt[i].e_we));
            chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
            chk($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(vt[i].e_wdata));
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        chk("oob_err_set", 32'(oob_err), 32'd1);

        // Back-to-back reads at 0,1,2
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = ADDR_W'(i);
            @(negedge clk);
            chk("seq_rd_ready", 32'(rd_ready), 32'd1);
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();
        chk("rd_q_drained_seq", 32'(rd_q.size()), 32'd0);

        // Contention: 8 reads then 1 write, repeating
        rd_req = 1'b1; wr_valid = 1'b1; wr_addr = ADDR_W'(50); wr_data = 8'h5A;
        for (int i = 0; i < 27; i++) begin
            rd_addr = ADDR_W'(100 + i);
            @(negedge clk);
            chk("cont_rd_ready", 32'(rd_ready), 32'((i % 9) != 8));
            chk("cont_wr_ready", 32'(wr_ready), 32'((i % 9) == 8));
            chk("cont_ram_we", 32'(ram_we), 32'((i % 9) == 8));
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();
        chk("oob_err_sticky", 32'(oob_err), 32'd1);

        // Clear with a pending write in the start cycle; second start ignored
        clr_exp = 0; done_cnt = 0;
        wr_valid = 1'b1; wr_addr = ADDR_W'(33); wr_data = 8'h77; clear_start = 1'b1;
        @(negedge clk);
        chk("start_cycle_wr_ready", 32'(wr_ready), 32'd1);
        chk("start_cycle_ram_we", 32'(ram_we), 32'd1);
        chk("start_cycle_ram_addr", 32'(ram_addr), 32'd33);
        run_clear(1'b0, 2 * DEPTH_T + 20, busy, got);
        chk("clear_done_seen", 32'(got), 32'd1);
        chk("clear_busy_cycles", 32'(busy), 32'(DEPTH_T));
        chk("clear_write_count", 32'(clr_exp), 32'(DEPTH_T));
        idle_inputs();
        repeat (4) next_cycle();
        chk("clear_done_once", 32'(done_cnt), 32'd1);

        // Clear with continuous reads: one clear write per 9 cycles
        clr_exp = 0; done_cnt = 0;
        rd_req = 1'b1; rd_addr = '0; clear_start = 1'b1;
        run_clear(1'b1, 12 * DEPTH_T, busy, got);
        chk("clr_rd_done_seen", 32'(got), 32'd1);
        chk("clr_rd_busy_cycles", 32'(busy), 32'(9 * DEPTH_T));
        chk("clr_rd_write_count", 32'(clr_exp), 32'(DEPTH_T));
        idle_inputs();
        repeat (4) next_cycle();
        chk("clr_rd_done_once", 32'(done_cnt), 32'd1);
        chk("rd_q_drained_clr", 32'(rd_q.size()), 32'd0);

        // Reset mid-clear at clear_cnt==100, then restart from 0
        clr_exp = 0; done_cnt = 0;
        clear_start = 1'b1;
        next_cycle();
        clear_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4 * DEPTH_T && !got; c++) begin
            @(posedge clk);
            if (clr_exp >= 100) got = 1'b1;
        end
        chk("reached_cnt_100", 32'(got), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_clear_busy", 32'(clear_busy), 32'd0);
        chk("mid_rst_clear_done", 32'(clear_done), 32'd0);
        chk("mid_rst_rd_valid", 32'(rd_data_valid), 32'd0);
        chk("mid_rst_oob_err", 32'(oob_err), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        rd_q.delete();
        clr_exp = 0;
        next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);
        chk("no_writes_after_abort", 32'(clr_exp), 32'd0);
        clear_start = 1'b1;
        run_clear(1'b0, 2 * DEPTH_T + 20, busy, got);
        chk("restart_done_seen", 32'(got), 32'd1);
        chk("restart_write_count", 32'(clr_exp), 32'(DEPTH_T));
        idle_inputs();
        repeat (2) next_cycle();

        // Read accepted the cycle before reset yields no valid afterwards
        rd_req = 1'b1; rd_addr = ADDR_W'(3);
        @(negedge clk);
        chk("pre_rst_rd_ready", 32'(rd_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1; rd_req = 1'b0;
        #1 chk("rst_kills_valid", 32'(rd_data_valid), 32'd0);
        rd_q.delete();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(rd_data_valid), 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
